// File: rtl/paint_pkg.sv
// Shared definitions for the paint cursor controller: palette, FSM states, joystick centre.
// The CLEAR state exists only when PAINT_CLEAR_EN is defined.
package paint_pkg;

  localparam int JSTK_CENTER = 512;
  localparam int PAL_W       = 12;

  // 4R,4G,4B entries selected by the sw inputs
  localparam logic [PAL_W-1:0] PALETTE [8] = '{
    12'h000, 12'hF00, 12'h0F0, 12'h00F,
    12'hFF0, 12'h0FF, 12'hF0F, 12'hFFF
  };

`ifdef PAINT_CLEAR_EN
  typedef enum logic [1:0] {IDLE, PAINT, CLEAR} state_t;
`else
  typedef enum logic [1:0] {IDLE, PAINT} state_t;
`endif

endpackage

// File: rtl/jstk_axis_step.sv
// Maps one 10-bit joystick sample to a signed cursor step in -2..2 with a dead zone.
module jstk_axis_step
  import paint_pkg::*;
#(
  parameter int DEAD = 64
) (
  input  logic        [9:0] sample,
  output logic signed [2:0] step
);

  logic signed [10:0] d;
  logic signed [10:0] mag;

  always_comb begin
    d    = $signed({1'b0, sample}) - $signed(11'(JSTK_CENTER));
    mag  = (d < 0) ? -d : d;
    step = 3'sd0;
    if (mag <= DEAD)          step = 3'sd0;
    else if (mag <= 4 * DEAD) step = (d < 0) ? -3'sd1 : 3'sd1;
    else                      step = (d < 0) ? -3'sd2 : 3'sd2;
  end

endmodule

// File: rtl/paint_cursor_ctrl.sv
// Joystick-driven paint cursor with a valid/ready framebuffer write channel.
// Optional full-screen clear on a btn[2] rising edge when PAINT_CLEAR_EN is defined.
module paint_cursor_ctrl
  import paint_pkg::*;
#(
  parameter int FB_W    = 160,
  parameter int FB_H    = 120,
  parameter int COORD_W = 8,
  parameter int COLOR_W = 12,
  parameter int BRUSH   = 2,
  parameter int DEAD    = 64,
  localparam int ADDR_W = $clog2(FB_W * FB_H)
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               move_tick,
  input  logic [9:0]         jstk_x,
  input  logic [9:0]         jstk_y,
  input  logic [2:0]         btn,
  input  logic [2:0]         sw,
  output logic [COORD_W-1:0] cur_x,
  output logic [COORD_W-1:0] cur_y,
  output logic               busy,
  output logic               wr_valid,
  input  logic               wr_ready,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [COLOR_W-1:0] wr_data
);

  localparam int X_MAX = FB_W - BRUSH;
  localparam int Y_MAX = FB_H - BRUSH;
  localparam logic [1:0]        BMAX      = 2'(BRUSH - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_W * FB_H - 1);

  state_t              state_q, state_d;
  logic signed [2:0]   step_x, step_y, neg_y;
  logic [COORD_W-1:0]  nx, ny;
  logic [1:0]          bi, bj, nbi, nbj;
  logic                last_cell, xfer, paint_req;
  logic [COLOR_W-1:0]  paint_data;

  function automatic logic [COORD_W-1:0] sat_move(input logic [COORD_W-1:0] c,
                                                  input logic signed [2:0] s,
                                                  input int hi);
    logic signed [COORD_W+1:0] t;
    t = $signed({2'b00, c}) + s;
    if (t < 0)       return '0;
    else if (t > hi) return COORD_W'(hi);
    else             return t[COORD_W-1:0];
  endfunction

  function automatic logic [ADDR_W-1:0] cell_addr(input logic [COORD_W-1:0] x,
                                                  input logic [COORD_W-1:0] y,
                                                  input logic [1:0] i,
                                                  input logic [1:0] j);
    return ADDR_W'((int'(y) + int'(j)) * FB_W + int'(x) + int'(i));
  endfunction

  jstk_axis_step #(.DEAD(DEAD)) u_step_x (.sample(jstk_x), .step(step_x));
  jstk_axis_step #(.DEAD(DEAD)) u_step_y (.sample(jstk_y), .step(step_y));

  // Joystick up means screen up, so the y step is inverted.
  assign neg_y = -step_y;
  assign nx    = sat_move(cur_x, step_x, X_MAX);
  assign ny    = sat_move(cur_y, neg_y, Y_MAX);
  assign busy  = (state_q != IDLE);

`ifdef PAINT_CLEAR_EN
  logic btn2_q;
  logic clear_req;
  assign clear_req = (state_q == IDLE) && btn[2] && !btn2_q;
`else
  logic unused_btn2;
  assign unused_btn2 = btn[2];
`endif

  always_comb begin
    xfer      = wr_valid && wr_ready;
    last_cell = (bi == BMAX) && (bj == BMAX);
    nbi       = (bi == BMAX) ? 2'd0 : bi + 2'd1;
    nbj       = (bi == BMAX) ? bj + 2'd1 : bj;
    paint_req = (state_q == IDLE) && move_tick && (btn[0] || btn[1]);
    state_d   = state_q;
    case (state_q)
      IDLE: begin
`ifdef PAINT_CLEAR_EN
        if (clear_req)      state_d = CLEAR;
        else if (paint_req) state_d = PAINT;
`else
        if (paint_req)      state_d = PAINT;
`endif
      end
      PAINT: if (xfer && last_cell) state_d = IDLE;
`ifdef PAINT_CLEAR_EN
      CLEAR: if (xfer && (wr_addr == LAST_ADDR)) state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q    <= IDLE;
      cur_x      <= COORD_W'(X_MAX / 2);
      cur_y      <= COORD_W'(Y_MAX / 2);
      wr_valid   <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      bi         <= '0;
      bj         <= '0;
      paint_data <= '0;
`ifdef PAINT_CLEAR_EN
      btn2_q     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
`ifdef PAINT_CLEAR_EN
      btn2_q  <= btn[2];
`endif
      case (state_q)
        IDLE: begin
          bi <= '0;
          bj <= '0;
          if (move_tick) begin
            cur_x <= nx;
            cur_y <= ny;
          end
          if (paint_req) paint_data <= btn[1] ? '0 : COLOR_W'(PALETTE[sw]);
        end
        // First cycle in a state presents the first write; later cycles advance on transfer.
        PAINT: begin
          if (!wr_valid) begin
            wr_valid <= 1'b1;
            wr_addr  <= cell_addr(cur_x, cur_y, bi, bj);
            wr_data  <= paint_data;
          end else if (xfer) begin
            if (last_cell) begin
              wr_valid <= 1'b0;
            end else begin
              bi      <= nbi;
              bj      <= nbj;
              wr_addr <= cell_addr(cur_x, cur_y, nbi, nbj);
            end
          end
        end
`ifdef PAINT_CLEAR_EN
        CLEAR: begin
          if (!wr_valid) begin
            wr_valid <= 1'b1;
            wr_addr  <= '0;
            wr_data  <= '0;
          end else if (xfer) begin
            if (wr_addr == LAST_ADDR) wr_valid <= 1'b0;
            else                      wr_addr  <= wr_addr + ADDR_W'(1);
          end
        end
`endif
        default: wr_valid <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_paint_cursor_ctrl.sv
// Scoreboard bench for paint_cursor_ctrl: directed cursor moves, brush paints, stalls and clears.
// Clear-screen scenarios run when PAINT_CLEAR_EN is defined.
module tb_paint_cursor_ctrl;

  logic        clk = 1'b0;
  logic        clr, move_tick;
  logic [9:0]  jstk_x, jstk_y;
  logic [2:0]  btn, sw;
  logic [7:0]  cur_x, cur_y;
  logic        busy, wr_valid;
  logic        wr_ready = 1'b1;
  logic [14:0] wr_addr;
  logic [11:0] wr_data;

  always #5 clk = ~clk;

  paint_cursor_ctrl dut (
    .clk(clk), .clr(clr), .move_tick(move_tick), .jstk_x(jstk_x), .jstk_y(jstk_y),
    .btn(btn), .sw(sw), .cur_x(cur_x), .cur_y(cur_y), .busy(busy),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  typedef struct {
    logic [14:0] addr;
    logic [11:0] data;
    bit          consec;
  } exp_t;

  exp_t        sbq[$];
  exp_t        e;
  int          tests = 0;
  int          fails = 0;
  int          n_xfer = 0;
  int          cyc = 0;
  int          last_cyc = -10;
  bit          prev_stall = 0;
  logic [14:0] hold_addr;
  logic [11:0] hold_data;
  logic        ready_cmd = 1'b1;
  bit          toggle_en = 0;

  localparam logic [11:0] PAL3 = 12'h00F;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick(input logic [9:0] x, input logic [9:0] y, input logic [2:0] b);
    jstk_x = x; jstk_y = y; btn = b; move_tick = 1'b1;
    step();
    move_tick = 1'b0;
  endtask

  task automatic push4(input logic [11:0] d, input bit consec);
    logic [14:0] a [4];
    a[0] = 15'd3210; a[1] = 15'd3211; a[2] = 15'd3370; a[3] = 15'd3371;
    for (int i = 0; i < 4; i++) sbq.push_back('{a[i], d, (i > 0) ? consec : 1'b0});
  endtask

  task automatic wait_done(input string name, input int bound);
    for (int i = 0; i < bound; i++) begin
      if (!busy && sbq.size() == 0) break;
      step();
    end
    chk({name, "_busy_done"}, busy, 0);
    chk({name, "_pending"}, sbq.size(), 0);
    step(); step(); step();
  endtask

  // Ready driver: fixed level or a 1/0 toggle, applied just after each rising edge.
  initial forever begin
    @(posedge clk);
    #2;
    wr_ready = toggle_en ? ~wr_ready : ready_cmd;
  end

  // Monitor: checks hold-during-stall and pops the scoreboard on every transfer.
  initial forever begin
    @(negedge clk);
    cyc++;
    if (prev_stall) begin
      tests++;
      if (!(wr_valid === 1'b1 && wr_addr === hold_addr && wr_data === hold_data)) begin
        fails++;
        $display("FAIL stall_hold: valid=%b addr=%0d data=%h required valid=1 addr=%0d data=%h",
                 wr_valid, wr_addr, wr_data, hold_addr, hold_data);
      end
    end
    if (wr_valid === 1'b1 && wr_ready === 1'b1) begin
      n_xfer++;
      tests++;
      if (sbq.size() == 0) begin
        fails++;
        $display("FAIL extra_write: addr=%0d data=%h required no transfer", wr_addr, wr_data);
      end else begin
        e = sbq.pop_front();
        if (wr_addr !== e.addr || wr_data !== e.data || (e.consec && cyc != last_cyc + 1)) begin
          fails++;
          $display("FAIL write: addr=%0d data=%h gap=%0d required addr=%0d data=%h consec=%0d",
                   wr_addr, wr_data, cyc - last_cyc, e.addr, e.data, e.consec);
        end
      end
      last_cyc = cyc;
    end
    prev_stall = (wr_valid === 1'b1) && (wr_ready === 1'b0) && !clr;
    hold_addr  = wr_addr;
    hold_data  = wr_data;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    clr = 1'b1; move_tick = 1'b0; jstk_x = 10'd512; jstk_y = 10'd512; btn = 3'b000; sw = 3'd0;
    step(); step();
    clr = 1'b0;
    chk("rst_cur_x", cur_x, 79);
    chk("rst_cur_y", cur_y, 59);
    chk("rst_busy", busy, 0);
    chk("rst_wr_valid", wr_valid, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);

    tick(10'd512, 10'd512, 3'b000);
    chk("centre_x", cur_x, 79);
    chk("centre_y", cur_y, 59);
    chk("centre_busy", busy, 0);

    for (int k = 1; k <= 100; k++) begin
      tick(10'd1023, 10'd0, 3'b000);
      chk("sat_x", cur_x, (79 + 2 * k > 158) ? 158 : 79 + 2 * k);
      chk("sat_y", cur_y, (59 + 2 * k > 118) ? 118 : 59 + 2 * k);
    end

    clr = 1'b1; step(); clr = 1'b0;
    chk("rst2_cur_x", cur_x, 79);
    for (int k = 0; k < 19; k++) tick(10'd0, 10'd1023, 3'b000);
    chk("nav_y_fast", cur_y, 21);
    for (int k = 0; k < 15; k++) tick(10'd0, 10'd512, 3'b000);
    chk("nav_x_fast", cur_x, 11);
    tick(10'd400, 10'd600, 3'b000);
    chk("nav_x_slow", cur_x, 10);
    chk("nav_y_slow", cur_y, 20);

    sw = 3'd3;
    push4(PAL3, 1'b1);
    tick(10'd512, 10'd512, 3'b001);
    btn = 3'b000;
    chk("paint_busy", busy, 1);
    wait_done("paint", 50);
    chk("paint_cur_x", cur_x, 10);
    chk("paint_cur_y", cur_y, 20);

    base = n_xfer;
    toggle_en = 1;
    push4(PAL3, 1'b0);
    tick(10'd512, 10'd512, 3'b001);
    for (int k = 0; k < 3; k++) tick(10'd1023, 10'd0, 3'b001);
    btn = 3'b000; jstk_x = 10'd512; jstk_y = 10'd512;
    wait_done("stall", 100);
    toggle_en = 0;
    ready_cmd = 1'b1;
    step();
    chk("stall_count", n_xfer - base, 4);
    chk("stall_cur_x", cur_x, 10);
    chk("stall_cur_y", cur_y, 20);

    push4(12'h000, 1'b1);
    tick(10'd512, 10'd512, 3'b011);
    btn = 3'b000;
    wait_done("erase", 50);

`ifdef PAINT_CLEAR_EN
    for (int a = 0; a < 19200; a++) sbq.push_back('{15'(a), 12'h000, (a > 0)});
    tick(10'd1023, 10'd512, 3'b100);
    btn = 3'b000;
    chk("clear_move_x", cur_x, 12);
    chk("clear_move_y", cur_y, 20);
    chk("clear_busy", busy, 1);
    wait_done("clear", 20000);

    base = n_xfer;
    for (int a = 0; a < 19200; a++) sbq.push_back('{15'(a), 12'h000, (a > 0)});
    btn = 3'b100; step(); btn = 3'b000;
    for (int i = 0; i < 1000; i++) begin
      if (n_xfer - base >= 100) break;
      step();
    end
    chk("abort_reached", n_xfer - base, 100);
    clr = 1'b1; ready_cmd = 1'b0;
    step();
    chk("abort_wr_valid", wr_valid, 0);
    chk("abort_busy", busy, 0);
    clr = 1'b0; ready_cmd = 1'b1;
    sbq.delete();
    step(); step(); step();
    chk("abort_total", n_xfer - base, 100);
    chk("abort_cur_x", cur_x, 79);
    chk("abort_cur_y", cur_y, 59);
`else
    base = n_xfer;
    btn = 3'b100; step(); btn = 3'b000; step(); step();
    chk("noclr_busy", busy, 0);
    chk("noclr_wr_valid", wr_valid, 0);
    chk("noclr_writes", n_xfer - base, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/paint_cursor_ctrl.md
PAINT_CURSOR_CTRL -- requirements
Module: paint_cursor_ctrl

Interface
REQ-001 SHALL have parameter FB_W, default 160, framebuffer width in pixels.
REQ-002 SHALL have parameter FB_H, default 120, framebuffer height in pixels.
REQ-003 SHALL have parameter COORD_W, default 8, cursor coordinate width.
REQ-004 SHALL have parameter COLOR_W, default 12, pixel width (4R,4G,4B).
REQ-005 SHALL have parameter BRUSH, default 2, brush square side in pixels (legal 1..4).
REQ-006 SHALL have parameter DEAD, default 64, joystick dead-zone half-width in counts.
REQ-007 SHALL have derived localparam ADDR_W = clog2(FB_W*FB_H).
REQ-008 clk  in  1  100 MHz system clock; all logic on rising edge.
REQ-009 clr  in  1  reset, synchronous, active-high.
REQ-010 move_tick  in  1  one-cycle pulse, once per frame; cursor update strobe.
REQ-011 jstk_x, jstk_y  in  10 each  latest joystick samples, 0..1023, centre 512.
REQ-012 btn  in  3  [0] paint, [1] erase, [2] clear screen; already debounced.
REQ-013 sw  in  3  palette index for paint colour.
REQ-014 cur_x, cur_y  out  COORD_W each  brush top-left pixel.
REQ-015 busy  out  1  high whenever the FSM is not IDLE.
REQ-016 wr_valid  out  1; wr_ready  in  1; wr_addr  out  ADDR_W; wr_data  out  COLOR_W  framebuffer write channel.

Function
REQ-017 SHALL implement FSM states IDLE, PAINT, CLEAR.
REQ-018 In IDLE on move_tick: per axis d = sample-512; |d|<=DEAD: step 0; DEAD<|d|<=4*DEAD: step 1; |d|>4*DEAD: step 2.
REQ-019 x moves by +sign(d_x)*step; y moves by -sign(d_y)*step (joystick up = screen up).
REQ-020 Cursor SHALL saturate to [0, FB_W-BRUSH] and [0, FB_H-BRUSH], with no wrap-around; new value visible the cycle after move_tick.
REQ-021 If btn[0] or btn[1] is high on the move_tick cycle, the next state SHALL be PAINT, using the updated cursor.
REQ-022 PAINT SHALL issue BRUSH*BRUSH writes, row-major, addr = (cur_y+j)*FB_W + (cur_x+i), then return to IDLE.
REQ-023 Write data SHALL be palette[sw] when btn[0] is high, else 0; btn[1] has priority over btn[0]; data and sw are latched on PAINT entry.
REQ-024 A write SHALL transfer only on wr_valid && wr_ready; wr_addr and wr_data SHALL stay stable while wr_valid && !wr_ready.
REQ-025 wr_valid SHALL rise the cycle after state entry; back-to-back writes are allowed when wr_ready stays high (1 write/cycle).
REQ-026 move_tick and buttons SHALL be ignored while busy; the cursor stays frozen.
REQ-027 Simultaneous clear request and move_tick in IDLE: CLEAR wins; the cursor still updates.

Reset
REQ-028 On clr: state=IDLE, cur_x=(FB_W-BRUSH)/2, cur_y=(FB_H-BRUSH)/2, busy=0, wr_valid=0, wr_addr=0, wr_data=0.
REQ-029 clr mid-PAINT/CLEAR SHALL abort the operation; wr_valid=0 after that edge, with no further transfers.

Configuration
REQ-030 Macro PAINT_CLEAR_EN defined: a btn[2] rising edge seen in IDLE enters CLEAR, which writes 0 to addresses 0..FB_W*FB_H-1 in order, then returns to IDLE.
REQ-031 PAINT_CLEAR_EN undefined: no CLEAR state and btn[2] is ignored; all other behaviour is identical.

Structure
REQ-032 Shared package paint_pkg SHALL hold the 8-entry COLOR_W palette, the FSM state enum, and JSTK_CENTER=512.
REQ-033 Sub-module jstk_axis_step SHALL map one 10-bit sample to a signed step (-2..2); it is instantiated twice.

Verification
REQ-034 Reset, then jstk (512,512), one move_tick -> cursor stays (79,59), busy=0.
REQ-035 jstk_x=1023 for 100 ticks -> cur_x increments 2/tick, saturates at 158, never wraps; jstk_y=0 gives cur_y increasing to 118.
REQ-036 Cursor (10,20), sw=3, btn[0], move_tick, wr_ready=1 -> 4 writes to addresses 3210, 3211, 3370, 3371 with data palette[3], on consecutive cycles.
REQ-037 Same as REQ-036 with wr_ready toggling 1/0 -> addr and data held during stalls; exactly 4 transfers; move_ticks during busy ignored.
REQ-038 btn[1]+btn[0] -> data 0; with PAINT_CLEAR_EN, btn[2] edge -> 19200 zero writes ending at addr 19199; clr asserted at write 100 -> wr_valid=0 the next cycle.
